// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among N byte requesters.
// Launches a frame, tracks tx_busy rise/fall, inserts an inter-frame gap, and times out a dead transmitter.
module uart_tx_arbiter #(
    parameter int N          = 4,
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 16,
    localparam int IDW       = (N > 1) ? $clog2(N) : 1,
    localparam int CMAX      = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES,
    localparam int CW        = $clog2(CMAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   req_data,
    output logic [N-1:0]         ack,
    output logic [WIDTH-1:0]     tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 active,
    output logic                 err_timeout
);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [IDW-1:0]    last, last_n;
    logic [IDW-1:0]    gid_n;
    logic [WIDTH-1:0]  data_n;
    logic [N-1:0]      ack_n;
    logic              start_n, err_n;
    logic [IDW-1:0]    pick, cand;
    logic              found;

    // First set request searching last+1, last+2, ... wrapping modulo N.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDW'((int'(last) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        last_n  = last;
        gid_n   = grant_id;
        data_n  = tx_data;
        ack_n   = '0;
        start_n = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (found && !tx_busy) begin
                    gid_n       = pick;
                    last_n      = pick;
                    data_n      = req_data[int'(pick)*WIDTH +: WIDTH];
                    ack_n[pick] = 1'b1;
                    start_n     = 1'b1;
                    state_n     = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_n   = '0;
                state_n = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // busy arriving on the last allowed cycle still counts as success
                if (tx_busy) begin
                    state_n = WAIT_DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    cnt_n   = '0;
                    state_n = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (cnt == CW'(GAP_CYCLES - 1)) state_n = IDLE;
                else                            cnt_n   = cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last        <= IDW'(N - 1);
            grant_id    <= '0;
            tx_data     <= '0;
            ack         <= '0;
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            active      <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            last        <= last_n;
            grant_id    <= gid_n;
            tx_data     <= data_n;
            ack         <= ack_n;
            tx_start    <= start_n;
            err_timeout <= err_n;
            active      <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: a scripted transmitter plus a frame-timeline reference model.
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int GAP = 2;
    localparam int TO  = 16;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   req_data = '0;
    logic             tx_busy = 1'b0;
    logic [N-1:0]     ack;
    logic [W-1:0]     tx_data;
    logic             tx_start;
    logic [IDW-1:0]   grant_id;
    logic             active;
    logic             err_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N(N), .WIDTH(W), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .grant_id(grant_id), .active(active), .err_timeout(err_timeout)
    );

    int n_vec = 0, n_err = 0, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Frame timeline in absolute cycle numbers: launch cycle, busy window, return to idle.
    int         L, idle_at, rise_at, fall_at, m_g, m_last;
    bit         to_frame, force3;
    logic [W-1:0] m_data;
    bit         pend [N];
    int         p_req, p_drop, p_again, p_busy, p_to;

    task automatic model_reset();
        L = -100; idle_at = 0; rise_at = -100; fall_at = -100;
        to_frame = 0; m_g = 0; m_last = N - 1; m_data = '0;
        for (int i = 0; i < N; i++) pend[i] = 0;
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        int best = -1, bd = N;
        for (int i = 0; i < N; i++) begin
            if (r[i] && ((i - last - 1 + 2*N) % N) < bd) begin
                bd = (i - last - 1 + 2*N) % N;
                best = i;
            end
        end
        return best;
    endfunction

    task automatic check_cycle(input int c);
        chk("tx_start", {31'd0, tx_start}, (c == L) ? 32'd1 : 32'd0);
        chk("ack", {28'd0, ack}, (c == L) ? (32'd1 << m_g) : 32'd0);
        chk("tx_data", {24'd0, tx_data}, {24'd0, m_data});
        chk("grant_id", {30'd0, grant_id}, 32'(m_g));
        chk("active", {31'd0, active}, (c < idle_at) ? 32'd1 : 32'd0);
        chk("err_timeout", {31'd0, err_timeout}, (to_frame && c == idle_at) ? 32'd1 : 32'd0);
    endtask

    task automatic drive(input int c);
        bit in_frame;
        in_frame = (c >= L) && (c < idle_at);
        tx_busy = in_frame ? (c >= rise_at && c < fall_at) : ($urandom_range(99) < p_busy);
        if (force3) begin
            for (int i = 0; i < N; i++) pend[i] = (i == 3);
            tx_busy = 1'b0;
            force3 = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (c == L + 1 && i == m_g)
                    pend[i] = ($urandom_range(99) < p_again);
                else if (pend[i]) begin
                    if (!(c == L && i == m_g) && $urandom_range(99) < p_drop) pend[i] = 0;
                end else if ($urandom_range(99) < p_req)
                    pend[i] = 1;
            end
        end
        for (int i = 0; i < N; i++) begin
            req[i] = pend[i];
            if ($urandom_range(1) == 1) req_data[i*W +: W] = W'($urandom);
        end
    endtask

    task automatic model_step(input int c);
        int g, d, sel, h;
        if (c >= idle_at && req != '0 && !tx_busy) begin
            g = rr_pick(req, m_last);
            m_g = g; m_last = g; m_data = req_data[g*W +: W];
            L = c + 1;
            to_frame = ($urandom_range(99) < p_to);
            if (to_frame) begin
                rise_at = -100; fall_at = -100; idle_at = L + 1 + TO;
            end else begin
                sel = $urandom_range(3);
                d = (sel == 0) ? 0 : (sel == 1) ? TO - 1 : $urandom_range(TO - 2, 1);
                h = $urandom_range(12, 1);
                rise_at = L + 1 + d;
                fall_at = rise_at + h;
                idle_at = fall_at + 1 + GAP;
            end
        end
    endtask

    initial begin
        bit did_rst;
        model_reset();
        force3 = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0: begin p_req = 30;  p_drop = 5;  p_again = 30;  p_busy = 20; p_to = 10; end
                1: begin p_req = 100; p_drop = 0;  p_again = 100; p_busy = 0;  p_to = 0;  end
                2: begin p_req = 40;  p_drop = 10; p_again = 50;  p_busy = 40; p_to = 50; end
                default: begin p_req = 10; p_drop = 20; p_again = 20; p_busy = 10; p_to = 20; end
            endcase
            did_rst = 0;
            for (int t = 0; t < 600; t++) begin
                check_cycle(cyc);
                if (!did_rst && t > 300 && !to_frame && cyc > rise_at && cyc <= fall_at) begin
                    // asynchronous reset in the middle of a busy frame
                    #2 rst = 1'b0;
                    #1;
                    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
                    chk("rst_ack", {28'd0, ack}, 32'd0);
                    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
                    chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
                    chk("rst_active", {31'd0, active}, 32'd0);
                    chk("rst_err", {31'd0, err_timeout}, 32'd0);
                    @(negedge clk);
                    rst = 1'b1;
                    model_reset();
                    force3 = 1;
                    did_rst = 1;
                    cyc++;
                    check_cycle(cyc);
                end
                drive(cyc);
                model_step(cyc);
                cyc++;
                @(negedge clk);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
